time_set_ctrl: RTL and testbench

- Button-driven controller that sequences manual time setting of the hour/minute counter block.
- Debounces two push-buttons and captures the current displayed time on entry to set mode.
- Steps through hour and minute edit states, then issues a single-cycle load of the edited BCD value.
- Drives hold and blink flags consumed by the counter block and the LCD string generator; sits beside the counter in the top level on the system clock.

---
 rtl/time_set_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// Manual time-set controller: debounced mode/inc buttons step RUN -> hour -> minute -> commit.
// Optional auto-repeat of held inc button under macro TIME_SET_AUTO_REPEAT_EN.
module time_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 20000,
  parameter int unsigned BLINK_CYC    = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [1:0] cur_hour_10,
  input  logic [3:0] cur_hour_1,
  input  logic [2:0] cur_min_10,
  input  logic [3:0] cur_min_1,
  output logic [1:0] set_hour_10,
  output logic [3:0] set_hour_1,
  output logic [2:0] set_min_10,
  output logic [3:0] set_min_1,
  output logic       load,
  output logic       hold,
  output logic       blink_hour,
  output logic       blink_min,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StSetHour = 2'd1,
    StSetMin  = 2'd2,
    StCommit  = 2'd3
  } state_e;

  localparam int unsigned DbW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYC - 1);
  localparam int unsigned BkW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [BkW-1:0] BkMax = BkW'(BLINK_CYC - 1);

  state_e state_q;

  // Bit 0 is the mode button, bit 1 the inc button.
  logic [1:0]          sync1_q, sync2_q, last_q, stable_q, stable_prev_q;
  logic [1:0][DbW-1:0] deb_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      last_q        <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      deb_cnt_q     <= '0;
    end else begin
      sync1_q       <= {btn_inc, btn_mode};
      sync2_q       <= sync1_q;
      last_q        <= sync2_q;
      stable_prev_q <= stable_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != last_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DbMax) begin
          stable_q[i] <= last_q[i];
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic mode_press, inc_press, inc_evt, in_edit;

  assign mode_press = stable_q[0] & ~stable_prev_q[0];
  // Mode has priority over a coincident inc press.
  assign inc_press  = stable_q[1] & ~stable_prev_q[1] & ~mode_press;
  assign in_edit    = (state_q == StSetHour) || (state_q == StSetMin);

`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam int unsigned RptStart  = 8 * BLINK_CYC;
  localparam int unsigned RptW      = $clog2(RptStart + 1);
  // Reload so the next fire lands exactly 2*BLINK_CYC cycles after this one.
  localparam logic [RptW-1:0] RptTop    = RptW'(RptStart);
  localparam logic [RptW-1:0] RptReload = RptW'(RptStart - 2 * BLINK_CYC + 1);

  logic [RptW-1:0] rpt_cnt_q;
  logic            rpt_fire;

  always_ff @(posedge clk) begin
    if (rst || !stable_q[1] || !in_edit || mode_press) begin
      rpt_cnt_q <= '0;
    end else if (rpt_cnt_q == RptTop) begin
      rpt_cnt_q <= RptReload;
    end else begin
      rpt_cnt_q <= rpt_cnt_q + 1'b1;
    end
  end

  assign rpt_fire = in_edit && stable_q[1] && !mode_press && (rpt_cnt_q == RptTop);
  assign inc_evt  = inc_press | rpt_fire;
`else
  assign inc_evt  = inc_press;
`endif

  logic enter_edit;
  logic [BkW-1:0] blink_cnt_q;
  logic           phase_q;

  assign enter_edit = mode_press && ((state_q == StRun) || (state_q == StSetHour));

  // Restart the blink cycle on entry so the edited digits are visible first.
  always_ff @(posedge clk) begin
    if (rst || enter_edit) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (blink_cnt_q == BkMax) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  function automatic logic [5:0] inc_hour(input logic [1:0] h10, input logic [3:0] h1);
    if (h10 > 2'd2 || h1 > 4'd9 || (h10 == 2'd2 && h1 > 4'd3)) return 6'd0;
    else if (h10 == 2'd2 && h1 == 4'd3)                          return 6'd0;
    else if (h1 == 4'd9)                                         return {h10 + 2'd1, 4'd0};
    else                                                         return {h10, h1 + 4'd1};
  endfunction

  function automatic logic [6:0] inc_min(input logic [2:0] m10, input logic [3:0] m1);
    if (m10 > 3'd5 || m1 > 4'd9)       return 7'd0;
    else if (m10 == 3'd5 && m1 == 4'd9) return 7'd0;
    else if (m1 == 4'd9)                return {m10 + 3'd1, 4'd0};
    else                                return {m10, m1 + 4'd1};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      set_hour_10 <= '0;
      set_hour_1  <= '0;
      set_min_10  <= '0;
      set_min_1   <= '0;
      load        <= 1'b0;
      hold        <= 1'b0;
    end else begin
      load <= 1'b0;
      unique case (state_q)
        StRun: begin
          if (mode_press) begin
            set_hour_10 <= cur_hour_10;
            set_hour_1  <= cur_hour_1;
            set_min_10  <= cur_min_10;
            set_min_1   <= cur_min_1;
            hold        <= 1'b1;
            state_q     <= StSetHour;
          end
        end
        StSetHour: begin
          if (mode_press) begin
            state_q <= StSetMin;
          end else if (inc_evt) begin
            {set_hour_10, set_hour_1} <= inc_hour(set_hour_10, set_hour_1);
          end
        end
        StSetMin: begin
          if (mode_press) begin
            load    <= 1'b1;
            state_q <= StCommit;
          end else if (inc_evt) begin
            {set_min_10, set_min_1} <= inc_min(set_min_10, set_min_1);
          end
        end
        StCommit: begin
          hold    <= 1'b0;
          state_q <= StRun;
        end
      endcase
    end
  end

  assign mode       = state_q;
  assign blink_hour = phase_q && (state_q == StSetHour);
  assign blink_min  = phase_q && (state_q == StSetMin);

endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomized self-checking bench for time_set_ctrl against an arithmetic time-setting model.
module tb_time_set_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned BLK = 8;
  localparam int unsigned HOLD_CYC = DEB + 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode, btn_inc;
  logic [1:0] cur_hour_10;
  logic [3:0] cur_hour_1;
  logic [2:0] cur_min_10;
  logic [3:0] cur_min_1;
  logic [1:0] set_hour_10;
  logic [3:0] set_hour_1;
  logic [2:0] set_min_10;
  logic [3:0] set_min_1;
  logic       load, hold, blink_hour, blink_min;
  logic [1:0] mode;

  time_set_ctrl #(
    .DEBOUNCE_CYC(DEB),
    .BLINK_CYC   (BLK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .cur_hour_10(cur_hour_10),
    .cur_hour_1 (cur_hour_1),
    .cur_min_10 (cur_min_10),
    .cur_min_1  (cur_min_1),
    .set_hour_10(set_hour_10),
    .set_hour_1 (set_hour_1),
    .set_min_10 (set_min_10),
    .set_min_1  (set_min_1),
    .load       (load),
    .hold       (hold),
    .blink_hour (blink_hour),
    .blink_min  (blink_min),
    .mode       (mode)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: editing position and digits as plain integers.
  int m_state;
  int m_h10, m_h1, m_m10, m_m1;
  int m_loads;

  int load_cnt = 0;
  int ld_h10, ld_h1, ld_m10, ld_m1;

  always @(negedge clk) begin
    if (load === 1'b1) begin
      load_cnt = load_cnt + 1;
      ld_h10 = set_hour_10;
      ld_h1  = set_hour_1;
      ld_m10 = set_min_10;
      ld_m1  = set_min_1;
    end
  end

  function automatic void model_inc_hour();
    int h;
    h = m_h10 * 10 + m_h1;
    if (m_h10 > 2 || m_h1 > 9 || h > 23) h = 0;
    else h = (h + 1) % 24;
    m_h10 = h / 10;
    m_h1  = h % 10;
  endfunction

  function automatic void model_inc_min();
    int mn;
    mn = m_m10 * 10 + m_m1;
    if (m_m10 > 5 || m_m1 > 9) mn = 0;
    else mn = (mn + 1) % 60;
    m_m10 = mn / 10;
    m_m1  = mn % 10;
  endfunction

  task automatic set_cur(input int h10, input int h1, input int m10, input int m1);
    cur_hour_10 = 2'(h10);
    cur_hour_1  = 4'(h1);
    cur_min_10  = 3'(m10);
    cur_min_1   = 4'(m1);
  endtask

  // Drive one debounced press and advance the model accordingly.
  task automatic press(input bit m, input bit i);
    @(negedge clk);
    btn_mode = m;
    btn_inc  = i;
    repeat (HOLD_CYC) @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (HOLD_CYC) @(negedge clk);
    if (m) begin
      case (m_state)
        0: begin
          m_h10 = cur_hour_10; m_h1 = cur_hour_1;
          m_m10 = cur_min_10;  m_m1 = cur_min_1;
          m_state = 1;
        end
        1: m_state = 2;
        2: begin m_state = 0; m_loads = m_loads + 1; end
        default: m_state = 0;
      endcase
    end else if (i) begin
      if (m_state == 1) model_inc_hour();
      else if (m_state == 2) model_inc_min();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_state = 0;
    m_h10 = 0; m_h1 = 0; m_m10 = 0; m_m1 = 0;
  endtask

  task automatic test_reset();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    set_cur(0, 0, 0, 0);
    m_loads = 0;
    do_reset();
    @(negedge clk);
    n_total++;
    if (mode !== 2'd0 || hold !== 1'b0 || load !== 1'b0)
      $display("FAIL reset_ctrl: mode=%0d hold=%b load=%b want 0/0/0", mode, hold, load);
    else n_pass++;
    n_total++;
    if ({set_hour_10, set_hour_1, set_min_10, set_min_1} !== 13'd0 ||
        blink_hour !== 1'b0 || blink_min !== 1'b0)
      $display("FAIL reset_data: set=%0d%0d:%0d%0d blink=%b%b want 00:00 blink 00",
               set_hour_10, set_hour_1, set_min_10, set_min_1, blink_hour, blink_min);
    else n_pass++;
  endtask

  task automatic test_glitch();
    @(negedge clk);
    btn_mode = 1'b1;
    repeat (2) @(negedge clk);
    btn_mode = 1'b0;
    repeat (3 * HOLD_CYC) @(negedge clk);
    n_total++;
    if (mode !== 2'd0 || hold !== 1'b0)
      $display("FAIL glitch: mode=%0d hold=%b want 0/0", mode, hold);
    else n_pass++;
  endtask

  task automatic test_edit_commit();
    int lc;
    set_cur(0, 9, 5, 8);
    press(1'b1, 1'b0);
    n_total++;
    if (mode !== 2'd1 || hold !== 1'b1)
      $display("FAIL enter_set_hour: mode=%0d hold=%b want 1/1", mode, hold);
    else n_pass++;
    n_total++;
    if (set_hour_10 !== 2'd0 || set_hour_1 !== 4'd9 || set_min_10 !== 3'd5 || set_min_1 !== 4'd8)
      $display("FAIL capture: set=%0d%0d:%0d%0d want 09:58",
               set_hour_10, set_hour_1, set_min_10, set_min_1);
    else n_pass++;
    press(1'b0, 1'b1);
    n_total++;
    if (set_hour_10 !== 2'd1 || set_hour_1 !== 4'd0)
      $display("FAIL hour_carry: hour=%0d%0d want 10", set_hour_10, set_hour_1);
    else n_pass++;
    press(1'b1, 1'b0);
    n_total++;
    if (mode !== 2'd2)
      $display("FAIL enter_set_min: mode=%0d want 2", mode);
    else n_pass++;
    lc = load_cnt;
    press(1'b1, 1'b0);
    n_total++;
    if (load_cnt - lc !== 1)
      $display("FAIL load_pulse: load cycles=%0d want 1", load_cnt - lc);
    else n_pass++;
    n_total++;
    if (ld_h10 !== 1 || ld_h1 !== 0 || ld_m10 !== 5 || ld_m1 !== 8)
      $display("FAIL load_value: got %0d%0d:%0d%0d want 10:58", ld_h10, ld_h1, ld_m10, ld_m1);
    else n_pass++;
    n_total++;
    if (mode !== 2'd0 || hold !== 1'b0)
      $display("FAIL after_commit: mode=%0d hold=%b want 0/0", mode, hold);
    else n_pass++;
  endtask

  task automatic test_wrap();
    set_cur(2, 3, 5, 9);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    n_total++;
    if (set_hour_10 !== 2'd0 || set_hour_1 !== 4'd0)
      $display("FAIL hour_wrap: hour=%0d%0d want 00", set_hour_10, set_hour_1);
    else n_pass++;
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    n_total++;
    if (set_min_10 !== 3'd0 || set_min_1 !== 4'd0 || set_hour_10 !== 2'd0 || set_hour_1 !== 4'd0)
      $display("FAIL min_wrap: set=%0d%0d:%0d%0d want 00:00",
               set_hour_10, set_hour_1, set_min_10, set_min_1);
    else n_pass++;
    press(1'b1, 1'b0);
  endtask

  task automatic test_out_of_range();
    set_cur(1, 12, 7, 3);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    n_total++;
    if (set_hour_10 !== 2'd0 || set_hour_1 !== 4'd0)
      $display("FAIL bad_hour: hour=%0d%0d want 00", set_hour_10, set_hour_1);
    else n_pass++;
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    n_total++;
    if (set_min_10 !== 3'd0 || set_min_1 !== 4'd0)
      $display("FAIL bad_min: min=%0d%0d want 00", set_min_10, set_min_1);
    else n_pass++;
    press(1'b1, 1'b0);
  endtask

  task automatic test_same_cycle();
    set_cur(1, 4, 2, 7);
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    n_total++;
    if (mode !== 2'd2 || set_hour_10 !== 2'd1 || set_hour_1 !== 4'd4)
      $display("FAIL mode_priority: mode=%0d hour=%0d%0d want 2 14", mode, set_hour_10, set_hour_1);
    else n_pass++;
  endtask

  // Entered from test_same_cycle in SET_MIN.
  task automatic test_blink_and_reset();
    int last_toggle, n_toggle, lc;
    bit prev, spacing_ok, hour_quiet;
    last_toggle = -1;
    n_toggle = 0;
    spacing_ok = 1'b1;
    hour_quiet = 1'b1;
    prev = blink_min;
    for (int k = 0; k < 6 * BLK; k++) begin
      @(negedge clk);
      if (blink_hour !== 1'b0) hour_quiet = 1'b0;
      if (blink_min !== prev) begin
        if (last_toggle >= 0 && (k - last_toggle) != BLK) spacing_ok = 1'b0;
        last_toggle = k;
        n_toggle++;
        prev = blink_min;
      end
    end
    n_total++;
    if (!spacing_ok || n_toggle < 4)
      $display("FAIL blink_min_period: toggles=%0d spacing_ok=%b want >=4 and 1",
               n_toggle, spacing_ok);
    else n_pass++;
    n_total++;
    if (!hour_quiet) $display("FAIL blink_hour_quiet: blink_hour seen 1 want 0");
    else n_pass++;
    lc = load_cnt;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_state = 0;
    n_total++;
    if (mode !== 2'd0 || hold !== 1'b0 || load !== 1'b0 || blink_min !== 1'b0 ||
        {set_hour_10, set_hour_1, set_min_10, set_min_1} !== 13'd0)
      $display("FAIL rst_mid_edit: mode=%0d hold=%b load=%b blink=%b want all 0",
               mode, hold, load, blink_min);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_total++;
    if (load_cnt !== lc) $display("FAIL rst_no_load: load cycles=%0d want 0", load_cnt - lc);
    else n_pass++;
  endtask

  task automatic test_random();
    int lc, nh, nm;
    for (int it = 0; it < 6; it++) begin
      set_cur($urandom_range(0, 2), $urandom_range(0, 9), $urandom_range(0, 5),
              $urandom_range(0, 9));
      if (cur_hour_10 == 2'd2 && cur_hour_1 > 4'd3) cur_hour_1 = 4'($urandom_range(0, 3));
      nh = $urandom_range(0, 4);
      nm = $urandom_range(0, 4);
      press(1'b1, 1'b0);
      for (int j = 0; j < nh; j++) press(1'b0, 1'b1);
      press(1'b1, 1'b0);
      for (int j = 0; j < nm; j++) press(1'b0, 1'b1);
      lc = load_cnt;
      press(1'b1, 1'b0);
      n_total++;
      if (load_cnt - lc !== 1 || ld_h10 !== m_h10 || ld_h1 !== m_h1 ||
          ld_m10 !== m_m10 || ld_m1 !== m_m1)
        $display("FAIL random_%0d: loads=%0d got %0d%0d:%0d%0d want 1 %0d%0d:%0d%0d", it,
                 load_cnt - lc, ld_h10, ld_h1, ld_m10, ld_m1, m_h10, m_h1, m_m10, m_m1);
      else n_pass++;
    end
  endtask

  task automatic test_auto_repeat();
    int held, incs, want;
    held = 8 * BLK + 6 * BLK;
    set_cur(1, 2, 0, 0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    @(negedge clk);
    btn_inc = 1'b1;
    repeat (held) @(negedge clk);
    btn_inc = 1'b0;
    repeat (HOLD_CYC) @(negedge clk);
    incs = 1;
`ifdef TIME_SET_AUTO_REPEAT_EN
    // Repeats fire at held-cycle offsets 8*BLK, 10*BLK, ... strictly inside the hold.
    if (held > 8 * BLK) incs = incs + (held - 8 * BLK - 1) / (2 * BLK) + 1;
`endif
    want = incs % 60;
    n_total++;
    if (set_min_10 * 10 + set_min_1 !== want || set_hour_10 !== 2'd1 || set_hour_1 !== 4'd2)
      $display("FAIL held_inc: set=%0d%0d:%0d%0d want 12:%0d", set_hour_10, set_hour_1,
               set_min_10, set_min_1, want);
    else n_pass++;
    press(1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    test_reset();
    test_glitch();
    test_edit_commit();
    test_wrap();
    test_out_of_range();
    test_same_cycle();
    test_blink_and_reset();
    test_random();
    test_auto_repeat();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
